// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory: access-size encodings, the
// clear/ready state type and the byte-lane mask helper.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    CLEAR,
    READY
  } mem_state_e;

  // Big-endian lanes: mask bit 3 is bits [31:24], i.e. byte offset 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b1000 >> off;
      SZ_HALF: m = off[1] ? 4'b0011 : 4'b1100;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_sized_ld_align.sv
// Load aligner: picks the addressed byte/half lane out of a 32-bit word and
// sign- or zero-extends it to 32 bits.
module ld_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        ld_uns,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = '0;
    case (offset)
      2'd0: byte_v = word[31:24];
      2'd1: byte_v = word[23:16];
      2'd2: byte_v = word[15:8];
      default: byte_v = word[7:0];
    endcase
    half_v = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{24{~ld_uns & byte_v[7]}}, byte_v};
      SZ_HALF: data = {{16{~ld_uns & half_v[15]}}, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed, parametrised data memory with sub-word access, alignment and
// range checking, and a one-word-per-cycle clear sequence after reset.
module data_mem_sized
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned IDX_W   = $clog2(DEPTH),
  parameter int unsigned TST_IDX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [1:0]  size,
  input  logic        ld_uns,
  output logic [31:0] RD,
  output logic        busy,
  output logic        misalign,
  output logic        oob,
  output logic        err,
  output logic [31:0] tst
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] TST_I    = IDX_W'(TST_IDX);

  logic [3:0][7:0] mem_q [DEPTH];

  mem_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_mask;
  logic [3:0][7:0]  wr_data;
  logic [31:0]      ld_data;

  assign idx  = A[IDX_W+1:2];
  assign off  = A[1:0];
  assign busy = (state_q == CLEAR);
  assign err  = err_q;
  assign oob  = |A[31:IDX_W+2];

  always_comb begin
    case (size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = A[0];
      default: misalign = |A[1:0];
    endcase
  end

  // Clearing and CPU stores share a single write port; the clear has priority
  // and any store attempted meanwhile is dropped and flagged.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_idx  = idx;
    wr_mask = lane_mask(size, off);
    case (size)
      SZ_BYTE: wr_data = {4{WD[7:0]}};
      SZ_HALF: wr_data = {2{WD[15:0]}};
      default: wr_data = WD;
    endcase
    if (state_q == CLEAR) begin
      wr_en   = ~rst;
      wr_idx  = ptr_q;
      wr_mask = '1;
      wr_data = '0;
      ptr_d   = ptr_q + IDX_W'(1);
      if (ptr_q == LAST_IDX) state_d = READY;
      if (WE) err_d = 1'b1;
    end else if (WE) begin
      if (misalign || oob) err_d = 1'b1;
      else                 wr_en = ~rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_mask[0]) mem_q[wr_idx][0] <= wr_data[0];
      if (wr_mask[1]) mem_q[wr_idx][1] <= wr_data[1];
      if (wr_mask[2]) mem_q[wr_idx][2] <= wr_data[2];
      if (wr_mask[3]) mem_q[wr_idx][3] <= wr_data[3];
    end
  end

  ld_align u_ld_align (
    .word   (mem_q[idx]),
    .offset (off),
    .size   (size),
    .ld_uns (ld_uns),
    .data   (ld_data)
  );

  assign RD  = (busy || misalign || oob) ? '0 : ld_data;
  assign tst = mem_q[TST_I];

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed self-checking bench for data_mem_sized (DEPTH=128, TST_IDX=5).
module tb_data_mem_sized;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned TSTI  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        ld_uns = 1'b0;
  logic [31:0] RD;
  logic        busy, misalign, oob, err;
  logic [31:0] tst;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_sized #(.DEPTH(DEPTH), .TST_IDX(TSTI)) dut (
    .clk(clk), .rst(rst), .A(A), .WD(WD), .WE(WE), .size(size), .ld_uns(ld_uns),
    .RD(RD), .busy(busy), .misalign(misalign), .oob(oob), .err(err), .tst(tst)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    A = a; WD = d; size = sz; WE = 1'b1;
    tick();
    WE = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    A = a; size = sz; ld_uns = uns; WE = 1'b0;
    #1;
  endtask

  // Release reset and count edges until busy falls (0 if it never does).
  task automatic run_clear(output int edges);
    edges = 0;
    rst = 1'b0;
    for (int e = 1; e <= int'(DEPTH) + 20; e++) begin
      tick();
      if (!busy) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int edges;
    int nbad;
    for (int i = 0; i < int'(DEPTH); i++) dut.mem_q[i] = 32'hA5A5_5A5A;
    rst = 1'b1; A = '0; size = 2'b10;
    tick(); tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h want 00000000", RD); end
    n_checks++; if (tst !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL reset_no_write got %h want a5a55a5a", tst); end
    run_clear(edges);
    n_checks++; if (edges != int'(DEPTH)) begin n_fail++; $display("FAIL clear_latency got %0d want %0d", edges, DEPTH); end
    nbad = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      load(32'(i * 4), 2'b10, 1'b0);
      if (RD !== 32'h0) nbad++;
    end
    n_checks++; if (nbad != 0) begin n_fail++; $display("FAIL clear_zero got %0d nonzero words want 0", nbad); end
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (50) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_clear_busy got %b want 1", busy); end
    rst = 1'b1; tick();
    run_clear(edges);
    n_checks++; if (edges != int'(DEPTH)) begin n_fail++; $display("FAIL restart_latency got %0d want %0d", edges, DEPTH); end
  endtask

  task automatic test_byte_half_store();
    store(32'h10, 32'h1122_3344, 2'b10);
    store(32'h11, 32'hFFFF_FFAA, 2'b00);
    load(32'h10, 2'b10, 1'b0);
    n_checks++; if (RD !== 32'h11AA_3344) begin n_fail++; $display("FAIL sb_lane got %h want 11aa3344", RD); end
    store(32'h12, 32'h1234_BEEF, 2'b01);
    load(32'h10, 2'b10, 1'b0);
    n_checks++; if (RD !== 32'h11AA_BEEF) begin n_fail++; $display("FAIL sh_lane got %h want 11aabeef", RD); end
    load(32'h11, 2'b00, 1'b1);
    n_checks++; if (RD !== 32'h0000_00AA) begin n_fail++; $display("FAIL lbu_11 got %h want 000000aa", RD); end
  endtask

  task automatic test_load_ext();
    store(32'h20, 32'h80FF_7F01, 2'b10);
    load(32'h20, 2'b00, 1'b0);
    n_checks++; if (RD !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_20 got %h want ffffff80", RD); end
    load(32'h20, 2'b00, 1'b1);
    n_checks++; if (RD !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_20 got %h want 00000080", RD); end
    load(32'h22, 2'b01, 1'b0);
    n_checks++; if (RD !== 32'h0000_7F01) begin n_fail++; $display("FAIL lh_22 got %h want 00007f01", RD); end
    load(32'h20, 2'b01, 1'b1);
    n_checks++; if (RD !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_20 got %h want 000080ff", RD); end
    load(32'h20, 2'b01, 1'b0);
    n_checks++; if (RD !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_20 got %h want ffff80ff", RD); end
    load(32'h21, 2'b00, 1'b0);
    n_checks++; if (RD !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL lb_21 got %h want ffffffff", RD); end
    load(32'h23, 2'b00, 1'b0);
    n_checks++; if (RD !== 32'h0000_0001) begin n_fail++; $display("FAIL lb_23 got %h want 00000001", RD); end
    load(32'h20, 2'b11, 1'b0);
    n_checks++; if (RD !== 32'h80FF_7F01) begin n_fail++; $display("FAIL size11_word got %h want 80ff7f01", RD); end
  endtask

  task automatic test_misalign();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre got %b want 0", err); end
    A = 32'h22; WD = 32'hDEAD_DEAD; size = 2'b10; WE = 1'b1;
    #1;
    n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL misalign_sw got %b want 1", misalign); end
    tick(); WE = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL misalign_err got %b want 1", err); end
    load(32'h20, 2'b10, 1'b0);
    n_checks++; if (RD !== 32'h80FF_7F01) begin n_fail++; $display("FAIL misalign_mem got %h want 80ff7f01", RD); end
    load(32'h23, 2'b01, 1'b0);
    n_checks++; if (RD !== 32'h0 || misalign !== 1'b1) begin n_fail++; $display("FAIL lh_23 got rd=%h mis=%b want 0/1", RD, misalign); end
    load(32'h22, 2'b01, 1'b0);
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL half_aligned got %b want 0", misalign); end
  endtask

  task automatic test_oob();
    int edges;
    rst = 1'b1; tick();
    run_clear(edges);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL oob_err_pre got %b want 0", err); end
    store(32'h0, 32'h1234_5678, 2'b10);
    A = 32'h200; WD = 32'hFFFF_FFFF; size = 2'b10; WE = 1'b1;
    #1;
    n_checks++; if (oob !== 1'b1 || RD !== 32'h0) begin n_fail++; $display("FAIL oob_flag got oob=%b rd=%h want 1/0", oob, RD); end
    tick(); WE = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oob_err got %b want 1", err); end
    load(32'h0, 2'b10, 1'b0);
    n_checks++; if (RD !== 32'h1234_5678) begin n_fail++; $display("FAIL oob_alias got %h want 12345678", RD); end
    load(32'h8000_0000, 2'b00, 1'b0);
    n_checks++; if (oob !== 1'b1) begin n_fail++; $display("FAIL oob_high got %b want 1", oob); end
    store(32'h1FC, 32'hA1B2_C3D4, 2'b10);
    load(32'h1FC, 2'b10, 1'b0);
    n_checks++; if (oob !== 1'b0 || RD !== 32'hA1B2_C3D4) begin n_fail++; $display("FAIL last_word got oob=%b rd=%h want 0/a1b2c3d4", oob, RD); end
  endtask

  task automatic test_busy_tst();
    int edges;
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (3) tick();
    store(32'h14, 32'h1111_1111, 2'b10);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL busy_err got %b want 1", err); end
    edges = 0;
    for (int e = 0; e < int'(DEPTH) + 20; e++) begin
      if (!busy) begin edges = 1; break; end
      tick();
    end
    n_checks++; if (edges != 1) begin n_fail++; $display("FAIL busy_timeout got busy=%b want 0", busy); end
    n_checks++; if (tst !== 32'h0) begin n_fail++; $display("FAIL busy_dropped got %h want 00000000", tst); end
    A = 32'(TSTI * 4); WD = 32'hCAFE_F00D; size = 2'b10; ld_uns = 1'b0; WE = 1'b1;
    #1;
    n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL same_cycle_old got %h want 00000000", RD); end
    tick(); WE = 1'b0;
    n_checks++; if (tst !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tst_tap got %h want cafef00d", tst); end
    n_checks++; if (RD !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL load_after_store got %h want cafef00d", RD); end
  endtask

  task automatic test_back_to_back();
    store(32'h40, 32'h0102_0304, 2'b10);
    store(32'h44, 32'h0000_0055, 2'b00);
    store(32'h46, 32'h0000_9988, 2'b01);
    store(32'h43, 32'h0000_00EE, 2'b00);
    load(32'h40, 2'b10, 1'b0);
    n_checks++; if (RD !== 32'h0102_03EE) begin n_fail++; $display("FAIL b2b_w40 got %h want 010203ee", RD); end
    load(32'h44, 2'b10, 1'b0);
    n_checks++; if (RD !== 32'h5500_9988) begin n_fail++; $display("FAIL b2b_w44 got %h want 55009988", RD); end
  endtask

  initial begin
    test_reset();
    test_byte_half_store();
    test_load_ext();
    test_misalign();
    test_oob();
    test_busy_tst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
